uart_msg_streamer: RTL and testbench

Parametrised UART message transmitter that combines a baud-rate generator, an 8N1/8N2 serializer and a writable message buffer in one clock domain.
- Host loads up to DEPTH bytes, then issues start.
- The block sends msg_len bytes once, or repeats them with a configurable idle gap between repetitions.
- Sits between board-level control logic and the uarttx pin. It replaces the separate divided-clock scheme with a single-clock, tick-enabled datapath.

---
 rtl/uart_msg_streamer.sv | 204 ++++++++++++++++++++
 tb/tb_uart_msg_streamer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_streamer.sv
// UART message streamer: DEPTH-byte message buffer, tick-enabled 8N1/8N2 serializer
// and baud counter in one clock domain; sends msg_len bytes once or in a loop.
module uart_msg_streamer #(
  parameter int BAUD_DIV  = 1250,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 0,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   msg_len,
  input  logic          start,
  input  logic          loop,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] byte_idx,
  output logic          tx
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int GW = (GAP_BITS > 2) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, GAP} state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic          stop_reg, stop_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [AW:0]   len_reg, len_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_reg;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] next_idx;
  logic          baud_tick;
  logic          last_byte;
  logic          stop_final;

  // Read-first buffer: a byte already moved into shreg_reg never sees later writes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  assign baud_tick  = (baud_reg == BAUD_LAST);
  assign last_byte  = ({1'b0, idx_reg} == (len_reg - (AW + 1)'(1)));
  assign stop_final = (stop_reg == STOP_LAST);
  assign next_idx   = last_byte ? '0 : idx_reg + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      stop_reg  <= 1'b0;
      gap_reg   <= '0;
      idx_reg   <= '0;
      len_reg   <= '0;
      shreg_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      stop_reg  <= stop_next;
      gap_reg   <= gap_next;
      idx_reg   <= idx_next;
      len_reg   <= len_next;
      shreg_reg <= shreg_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    stop_next  = stop_reg;
    gap_next   = gap_reg;
    idx_next   = idx_reg;
    len_next   = len_reg;
    shreg_next = shreg_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    rd_addr    = idx_reg;

    if (state_reg != IDLE && state_reg != LOAD) begin
      baud_next = baud_tick ? '0 : baud_reg + BW'(1);
    end

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        rd_addr   = '0;
        if (start && msg_len != '0) begin
          len_next   = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
          idx_next   = '0;
          busy_next  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        shreg_next = rd_data_reg;
        tx_next    = 1'b0;
        baud_next  = '0;
        state_next = START;
      end
      START: begin
        if (baud_tick) begin
          bit_next   = '0;
          tx_next    = shreg_reg[0];
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_reg == 3'd7) begin
            stop_next  = 1'b0;
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_next   = bit_reg + 3'd1;
            shreg_next = {1'b0, shreg_reg[7:1]};
            tx_next    = shreg_reg[1];
          end
        end
      end
      STOP: begin
        // Prefetch the following byte so the next start bit follows with no idle clock.
        rd_addr   = next_idx;
        done_next = stop_final && last_byte && (baud_reg == BAUD_PRE);
        if (baud_tick) begin
          if (!stop_final) begin
            stop_next = 1'b1;
          end else if (!last_byte || (loop && GAP_BITS == 0)) begin
            idx_next   = next_idx;
            shreg_next = rd_data_reg;
            tx_next    = 1'b0;
            state_next = START;
          end else if (loop) begin
            gap_next   = '0;
            state_next = GAP;
          end else begin
            idx_next   = '0;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        rd_addr = '0;
        if (baud_tick) begin
          if (gap_reg == GAP_LAST) begin
            idx_next   = '0;
            shreg_next = rd_data_reg;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            gap_next = gap_reg + GW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      state_next = IDLE;
      baud_next  = '0;
      idx_next   = '0;
      tx_next    = 1'b1;
      busy_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

  assign tx       = tx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign byte_idx = idx_reg;

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Directed bench for uart_msg_streamer: two instances (1 stop + 2-bit gap, 2 stop + no gap)
// share stimulus; frames are checked bit by bit against hand-computed serial patterns.
module tb_uart_msg_streamer;

  localparam int BD = 4;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [9:0] frame;  // transmit order, first bit in [9]
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, wr_en, start, loop, abort;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] msg_len;
  logic       busy1, done1, tx1, busy2, done2, tx2;
  logic [3:0] idx1, idx2;
  logic       sel = 1'b0;
  logic       busy_m, done_m, tx_m;
  logic [3:0] idx_m;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_idx = 0;
  int fall_cyc = 0;
  int total = 0;
  int bad = 0;
  int d0;

  vec_t       tbl [6];
  logic [9:0] fr55;

  always #5 clk = ~clk;

  uart_msg_streamer #(.BAUD_DIV(BD), .DEPTH(16), .STOP_BITS(1), .GAP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .loop(loop), .abort(abort),
    .busy(busy1), .done(done1), .byte_idx(idx1), .tx(tx1)
  );

  uart_msg_streamer #(.BAUD_DIV(BD), .DEPTH(16), .STOP_BITS(2), .GAP_BITS(0)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .loop(loop), .abort(abort),
    .busy(busy2), .done(done2), .byte_idx(idx2), .tx(tx2)
  );

  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;
  assign tx_m   = sel ? tx2 : tx1;
  assign idx_m  = sel ? idx2 : idx1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_m) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      done_idx <= 32'(idx_m);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic quiesce();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

  // Start is sampled at the next edge; tx must fall exactly one edge later.
  task automatic launch(input string tag, input int len, input bit lp);
    msg_len = 5'(len);
    loop = lp;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_up"}, 32'(busy_m), 32'd1);
    check({tag, "_tx_still_hi"}, 32'(tx_m), 32'd1);
    step();
    check({tag, "_tx_fall"}, 32'(tx_m), 32'd0);
    fall_cyc = cyc;
  endtask

  // Entered on the first start-bit cycle; leaves on the cycle after the last stop cycle.
  task automatic check_frame(input string tag, input logic [9:0] fr, input int nstop,
                             input int idx, input bit last);
    int   nb = 9 + nstop;
    int   errs;
    logic expb;
    check({tag, "_idx"}, 32'(idx_m), 32'(idx));
    for (int b = 0; b < nb; b++) begin
      expb = (b < 10) ? fr[9-b] : 1'b1;
      errs = 0;
      for (int c = 0; c < BD; c++) begin
        if (tx_m !== expb) errs++;
        if (b == nb - 1 && c == BD - 1) check({tag, "_done"}, 32'(done_m), 32'(last));
        step();
        wr_en = 1'b0;
      end
      check($sformatf("%s_bit%0d", tag, b), errs, 0);
    end
    $display("frame %s idx=%0d bits=%b stop=%0d", tag, idx, fr, nstop);
  endtask

  task automatic check_quiet(input string tag, input int n);
    int errs = 0;
    for (int k = 0; k < n; k++) begin
      if (tx_m !== 1'b1 || busy_m !== 1'b0) errs++;
      step();
    end
    check(tag, errs, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'd0, 8'h41, 10'b0100000101};
    tbl[1] = '{4'd1, 8'h4C, 10'b0001100101};
    tbl[2] = '{4'd2, 8'h49, 10'b0100100101};
    tbl[3] = '{4'd3, 8'h43, 10'b0110000101};
    tbl[4] = '{4'd4, 8'h45, 10'b0101000101};
    tbl[5] = '{4'd5, 8'h0A, 10'b0010100001};
    fr55   = 10'b0101010101;

    rst = 1'b1; wr_en = 1'b0; start = 1'b0; loop = 1'b0; abort = 1'b0;
    wr_addr = '0; wr_data = '0; msg_len = '0;
    step(); step(); step();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      check($sformatf("rst_tx_d%0d", s), 32'(tx_m), 32'd1);
      check($sformatf("rst_busy_d%0d", s), 32'(busy_m), 32'd0);
      check($sformatf("rst_done_d%0d", s), 32'(done_m), 32'd0);
      check($sformatf("rst_idx_d%0d", s), 32'(idx_m), 32'd0);
    end
    sel = 1'b0;
    for (int i = 0; i < 6; i++) wr(tbl[i].addr, tbl[i].data);

    // Single message, 6 bytes, 8N1.
    quiesce();
    d0 = done_cnt;
    launch("once", 6, 1'b0);
    for (int i = 0; i < 6; i++) check_frame($sformatf("once%0d", i), tbl[i].frame, 1, i, i == 5);
    check("once_busy_fall", 32'(busy_m), 32'd0);
    check("once_len", 32'(done_cyc - fall_cyc + 1), 32'd240);
    check("once_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_quiet("once_quiet", 20);

    // Loop with 2-bit gap; addr 5 rewritten while byte 5 shifts; loop cleared in 2nd message.
    quiesce();
    d0 = done_cnt;
    launch("loop", 6, 1'b1);
    for (int i = 0; i < 5; i++) check_frame($sformatf("loopA%0d", i), tbl[i].frame, 1, i, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
    check_frame("loopA5", tbl[5].frame, 1, 5, 1'b1);
    begin
      int errs = 0;
      for (int k = 0; k < 2 * BD; k++) begin
        if (tx_m !== 1'b1 || busy_m !== 1'b1) errs++;
        step();
      end
      check("loop_gap", errs, 0);
    end
    check_frame("loopB0", tbl[0].frame, 1, 0, 1'b0);
    loop = 1'b0;
    for (int i = 1; i < 5; i++) check_frame($sformatf("loopB%0d", i), tbl[i].frame, 1, i, 1'b0);
    check_frame("loopB5", fr55, 1, 5, 1'b1);
    check("loop_done_cnt", 32'(done_cnt - d0), 32'd2);
    check_quiet("loop_quiet", 20);
    wr(4'd5, 8'h0A);

    // Abort during data bit 3 of byte 2, then a fresh start resends from byte 0.
    quiesce();
    d0 = done_cnt;
    launch("abt", 6, 1'b0);
    check_frame("abt0", tbl[0].frame, 1, 0, 1'b0);
    check_frame("abt1", tbl[1].frame, 1, 1, 1'b0);
    check("abt_idx2", 32'(idx_m), 32'd2);
    for (int k = 0; k < 4 * BD; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_tx", 32'(tx_m), 32'd1);
    check("abt_busy", 32'(busy_m), 32'd0);
    check("abt_idx", 32'(idx_m), 32'd0);
    check_quiet("abt_quiet", 20);
    check("abt_no_done", 32'(done_cnt - d0), 32'd0);
    launch("rst0", 6, 1'b0);
    check_frame("resend0", tbl[0].frame, 1, 0, 1'b0);
    quiesce();
    check("resend_abort_busy", 32'(busy_m), 32'd0);

    // abort with start in IDLE, and start with msg_len=0.
    msg_len = 5'd6; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_wins_busy", 32'(busy_m), 32'd0);
    msg_len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("len0_busy", 32'(busy_m), 32'd0);
    check_quiet("len0_quiet", 10);

    // msg_len=20 clamps to 16 bytes; a start while busy is ignored.
    for (int a = 6; a < 16; a++) wr(4'(a), 8'(8'h30 + a));
    d0 = done_cnt;
    launch("clamp", 20, 1'b0);
    for (int k = 0; k < 100; k++) step();
    msg_len = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 700 && busy_m === 1'b1; k++) step();
    check("clamp_timeout", 32'(busy_m), 32'd0);
    check("clamp_len", 32'(done_cyc - fall_cyc + 1), 32'd640);
    check("clamp_last_idx", 32'(done_idx), 32'd15);
    check("clamp_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Synchronous reset held 3 cycles mid-transmission.
    quiesce();
    d0 = done_cnt;
    launch("rstm", 6, 1'b0);
    for (int k = 0; k < 30; k++) step();
    rst = 1'b1;
    step();
    check("rstm_tx", 32'(tx_m), 32'd1);
    check("rstm_busy", 32'(busy_m), 32'd0);
    check("rstm_done", 32'(done_m), 32'd0);
    check("rstm_idx", 32'(idx_m), 32'd0);
    step(); step();
    rst = 1'b0;
    check_quiet("rstm_quiet", 60);
    check("rstm_no_done", 32'(done_cnt - d0), 32'd0);

    // Two stop bits, no gap: back-to-back restart in loop mode.
    quiesce();
    sel = 1'b1;
    step();
    d0 = done_cnt;
    launch("s2", 6, 1'b1);
    for (int i = 0; i < 6; i++) check_frame($sformatf("s2A%0d", i), tbl[i].frame, 2, i, i == 5);
    check("s2_len", 32'(done_cyc - fall_cyc + 1), 32'd264);
    check_frame("s2B0", tbl[0].frame, 2, 0, 1'b0);
    loop = 1'b0;
    for (int i = 1; i < 6; i++) check_frame($sformatf("s2B%0d", i), tbl[i].frame, 2, i, i == 5);
    check("s2_done_cnt", 32'(done_cnt - d0), 32'd2);
    check_quiet("s2_quiet", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
